flot_rec_check: RTL



---
 rtl/flot_rec_pkg.sv | 47 ++++
 rtl/flot_rec_dly.sv | 27 ++
 rtl/flot_rec_check.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/flot_rec_pkg.sv
// Shared defaults and float field helpers for the reciprocal result checker.
// Helpers take a 64-bit container so one definition serves any float width
// up to 64 bits; callers size the result back down with a cast.
package flot_rec_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_WIDTH_EXP = 8;
  localparam int DEF_WIDTH_MAT = 23;
  localparam int DEF_TOL_ULP   = 4;

  function automatic int bias_of(input int width_exp);
    return (1 << (width_exp - 1)) - 1;
  endfunction

  function automatic logic [63:0] low_mask(input int n);
    logic [63:0] m;
    m = '1;
    if (n < 64) m = ~({64{1'b1}} << n);
    return m;
  endfunction

  function automatic logic get_sign(input logic [63:0] x, input int width);
    logic [63:0] t;
    t = x >> (width - 1);
    return t[0];
  endfunction

  function automatic logic [63:0] get_exp(input logic [63:0] x, input int width_exp,
                                          input int width_mat);
    return (x >> width_mat) & low_mask(width_exp);
  endfunction

  function automatic logic [63:0] get_mat(input logic [63:0] x, input int width_mat);
    return x & low_mask(width_mat);
  endfunction

  function automatic logic is_zero(input logic [63:0] x, input int width);
    return (x & low_mask(width)) == 64'd0;
  endfunction

  // Exponent all-ones: infinity or NaN, nothing meaningful to check.
  function automatic logic is_special(input logic [63:0] x, input int width_exp,
                                      input int width_mat);
    return get_exp(x, width_exp, width_mat) == low_mask(width_exp);
  endfunction

endpackage

// File: rtl/flot_rec_dly.sv
// CE-gated shift register; aligns operand-side data with the pipeline output.
module flot_rec_dly #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  // Shift one place per enabled cycle; hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (ce_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/flot_rec_check.sv
// On-line checker for reciprocal pipelines: OP*result must be 1.0 within
// TOL_ULP. Optional first-failure capture is enabled by FLOT_REC_CHK_CAPTURE_EN.
module flot_rec_check
  import flot_rec_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WIDTH_exp = DEF_WIDTH_EXP,
  parameter int WIDTH_mat = DEF_WIDTH_MAT,
  parameter int LATENCY   = 6,
  parameter int TOL_ULP   = DEF_TOL_ULP,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             CE,
  input  logic             IN_VLD,
  input  logic [WIDTH-1:0] OP,
  input  logic             exce_in,
  input  logic [WIDTH-1:0] result,
  input  logic             exce_out,
  output logic             chk_vld,
  output logic             chk_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt
`ifdef FLOT_REC_CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] fail_op,
  output logic [WIDTH-1:0] fail_res,
  output logic [CNT_W-1:0] fail_idx
`endif
);

  localparam int MW   = WIDTH_mat + 1;
  localparam int PW   = 2 * MW;
  localparam int EW   = WIDTH_exp + 2;
  localparam int BIAS = bias_of(WIDTH_exp);
  localparam logic [EW-1:0] ESUM_ONE   = EW'(2 * BIAS);
  localparam logic [EW-1:0] ESUM_BELOW = EW'(2 * BIAS - 1);
  localparam logic [MW-1:0] TOL_V      = MW'(TOL_ULP);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [WIDTH+1:0] tail;
  logic             tail_vld, tail_ein;
  logic [WIDTH-1:0] tail_op;

  flot_rec_dly #(.W(WIDTH + 2), .DEPTH(LATENCY)) u_dly (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .ce_i   (CE),
    .d_i    ({IN_VLD, exce_in, OP}),
    .q_o    (tail)
  );

  assign tail_vld = tail[WIDTH+1];
  assign tail_ein = tail[WIDTH];
  assign tail_op  = tail[WIDTH-1:0];

  logic [63:0]          op_x, res_x;
  logic [WIDTH_exp-1:0] e_op, e_res;
  logic [WIDTH_mat-1:0] m_op, m_res;
  logic                 skip_d, sgn_eq_d;
  logic [EW-1:0]        esum_d;
  logic [PW-1:0]        prod_d;

  assign op_x     = 64'(tail_op);
  assign res_x    = 64'(result);
  assign e_op     = WIDTH_exp'(get_exp(op_x, WIDTH_exp, WIDTH_mat));
  assign e_res    = WIDTH_exp'(get_exp(res_x, WIDTH_exp, WIDTH_mat));
  assign m_op     = WIDTH_mat'(get_mat(op_x, WIDTH_mat));
  assign m_res    = WIDTH_mat'(get_mat(res_x, WIDTH_mat));
  assign sgn_eq_d = get_sign(op_x, WIDTH) == get_sign(res_x, WIDTH);
  assign skip_d   = tail_ein | exce_out | is_zero(op_x, WIDTH)
                  | is_special(op_x, WIDTH_exp, WIDTH_mat);
  assign esum_d   = EW'(e_op) + EW'(e_res);
  assign prod_d   = PW'({1'b1, m_op}) * PW'({1'b1, m_res});

  logic             s1_vld_q, s1_skip_q, s1_sgn_eq_q;
  logic [EW-1:0]    s1_esum_q;
  logic [PW-1:0]    s1_prod_q;
`ifdef FLOT_REC_CHK_CAPTURE_EN
  logic [WIDTH-1:0] s1_op_q, s1_res_q;
`endif

  // Stage 1: register the mantissa product and exponent sum of the aligned pair.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_vld_q    <= 1'b0;
      s1_skip_q   <= 1'b0;
      s1_sgn_eq_q <= 1'b0;
      s1_esum_q   <= '0;
      s1_prod_q   <= '0;
`ifdef FLOT_REC_CHK_CAPTURE_EN
      s1_op_q     <= '0;
      s1_res_q    <= '0;
`endif
    end else if (CE) begin
      s1_vld_q    <= tail_vld;
      s1_skip_q   <= skip_d;
      s1_sgn_eq_q <= sgn_eq_d;
      s1_esum_q   <= esum_d;
      s1_prod_q   <= prod_d;
`ifdef FLOT_REC_CHK_CAPTURE_EN
      s1_op_q     <= tail_op;
      s1_res_q    <= result;
`endif
    end
  end

  logic [PW-1:0]        prod_n;
  logic [EW-1:0]        esum_n;
  logic [WIDTH_mat-1:0] frac_t;
  logic [MW-1:0]        err_ulp;
  logic                 pass_d, chk_err_d;

  // Stage 2: normalize, measure distance from 1.0 in ulps, decide pass/fail.
  // Below 1.0 the distance is taken against 2.0 in the lower binade's mantissa.
  always_comb begin
    prod_n  = s1_prod_q;
    esum_n  = s1_esum_q;
    err_ulp = '0;
    pass_d  = 1'b0;
    if (s1_prod_q[PW-1]) begin
      prod_n = s1_prod_q >> 1;
      esum_n = s1_esum_q + EW'(1);
    end
    frac_t = prod_n[PW-3 -: WIDTH_mat];
    if (esum_n == ESUM_ONE) begin
      err_ulp = {1'b0, frac_t};
      pass_d  = s1_sgn_eq_q && (err_ulp <= TOL_V);
    end else if (esum_n == ESUM_BELOW) begin
      err_ulp = (MW'(1) << WIDTH_mat) - {1'b0, frac_t};
      pass_d  = s1_sgn_eq_q && (err_ulp <= TOL_V);
    end
    chk_err_d = s1_vld_q & ~s1_skip_q & ~pass_d;
  end

  logic             chk_vld_q, chk_err_q, err_sticky_q;
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q, skip_cnt_q;
`ifdef FLOT_REC_CHK_CAPTURE_EN
  logic [WIDTH-1:0] fail_op_q, fail_res_q;
  logic [CNT_W-1:0] fail_idx_q;
`endif

  // Result stage: strobe, saturating counters, sticky error and first-failure capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      chk_vld_q    <= 1'b0;
      chk_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      skip_cnt_q   <= '0;
`ifdef FLOT_REC_CHK_CAPTURE_EN
      fail_op_q    <= '0;
      fail_res_q   <= '0;
      fail_idx_q   <= '0;
`endif
    end else if (CE) begin
      chk_vld_q <= s1_vld_q;
      chk_err_q <= chk_err_d;
      if (s1_vld_q) begin
        if (s1_skip_q)   skip_cnt_q <= sat_inc(skip_cnt_q);
        else if (pass_d) pass_cnt_q <= sat_inc(pass_cnt_q);
        else             fail_cnt_q <= sat_inc(fail_cnt_q);
      end
      if (chk_err_d) err_sticky_q <= 1'b1;
`ifdef FLOT_REC_CHK_CAPTURE_EN
      if (chk_err_d && !err_sticky_q) begin
        fail_op_q  <= s1_op_q;
        fail_res_q <= s1_res_q;
        fail_idx_q <= pass_cnt_q + fail_cnt_q + skip_cnt_q;
      end
`endif
    end
  end

  // The strobe is held across CE-low cycles and shown on the next enabled cycle.
  assign chk_vld    = chk_vld_q & CE;
  assign chk_err    = chk_err_q & CE;
  assign err_sticky = err_sticky_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign skip_cnt   = skip_cnt_q;
`ifdef FLOT_REC_CHK_CAPTURE_EN
  assign fail_op    = fail_op_q;
  assign fail_res   = fail_res_q;
  assign fail_idx   = fail_idx_q;
`endif

endmodule
